// File: rtl/key_entry_ctrl_if.sv
// Keypad/display signal bundle for key_entry_ctrl: scanner-side inputs plus the
// digit-scan and status outputs.
interface key_entry_ctrl_if;
    logic       pressed;
    logic [3:0] key;
    logic       en;
    logic [2:0] sel;
    logic [3:0] out;
    logic       blank;
    logic [3:0] count;
    logic       full;
    logic       err;

    modport master (
        output pressed, key, en,
        input  sel, out, blank, count, full, err
    );

    modport slave (
        input  pressed, key, en,
        output sel, out, blank, count, full, err
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad digit-entry controller: 8-digit shift buffer with backspace/clear and an
// 8-slot display scanner. Define KEY_DEBOUNCE_EN to add a DB_CYCLES press debounce.
module key_entry_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 500000
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    key_entry_ctrl_if.slave  kif
);

`ifdef KEY_DEBOUNCE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_HELD} state_t;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    logic [DW-1:0] db_cnt_reg, db_cnt_next;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_HELD} state_t;
`endif

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    state_t        state_reg, state_next;
    logic          accept;
    logic [3:0]    digit_reg [8];
    logic [3:0]    up_src [8];
    logic [3:0]    dn_src [8];
    logic [3:0]    count_reg;
    logic          err_reg;
    logic [PW-1:0] prescale_reg;
    logic [2:0]    sel_reg;

    logic event_ok, is_digit, is_bs, is_clr, full_w;
    logic shift_up, shift_down, clear_all, err_next;

    // Key FSM: exactly one accept per press, whatever en says
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
`ifdef KEY_DEBOUNCE_EN
            db_cnt_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
`ifdef KEY_DEBOUNCE_EN
            db_cnt_reg <= db_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
`ifdef KEY_DEBOUNCE_EN
        db_cnt_next = db_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (kif.pressed) begin
`ifdef KEY_DEBOUNCE_EN
                    // The IDLE sample is the first of the DB_CYCLES high samples
                    state_next  = ST_DEBOUNCE;
                    db_cnt_next = DW'(1);
`else
                    accept      = 1'b1;
                    state_next  = ST_HELD;
`endif
                end
            end
`ifdef KEY_DEBOUNCE_EN
            ST_DEBOUNCE: begin
                if (!kif.pressed) begin
                    state_next  = ST_IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    accept      = 1'b1;
                    state_next  = ST_HELD;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt_reg + DW'(1);
                end
            end
`endif
            ST_HELD: begin
                if (!kif.pressed) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign event_ok   = accept && kif.en;
    assign is_digit   = (kif.key <= 4'd9);
    assign is_bs      = (kif.key == 4'hB);
    assign is_clr     = (kif.key == 4'hC);
    assign full_w     = (count_reg == 4'd8);
    assign shift_up   = event_ok && is_digit && !full_w;
    assign shift_down = event_ok && is_bs && (count_reg != 4'd0);
    assign clear_all  = event_ok && is_clr;
    assign err_next   = event_ok && ((is_digit && full_w) || (is_bs && (count_reg == 4'd0)));

    // Neighbour taps for shifting in each direction; the ends take key / zero
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign up_src[gi] = kif.key;
            end else begin : g_mid_up
                assign up_src[gi] = digit_reg[gi-1];
            end
            if (gi == 7) begin : g_last
                assign dn_src[gi] = 4'd0;
            end else begin : g_mid_dn
                assign dn_src[gi] = digit_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) digit_reg[i] <= 4'd0;
            count_reg <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (clear_all) begin
                for (int i = 0; i < 8; i++) digit_reg[i] <= 4'd0;
                count_reg <= 4'd0;
            end else if (shift_up) begin
                for (int i = 0; i < 8; i++) digit_reg[i] <= up_src[i];
                count_reg <= count_reg + 4'd1;
            end else if (shift_down) begin
                for (int i = 0; i < 8; i++) digit_reg[i] <= dn_src[i];
                count_reg <= count_reg - 4'd1;
            end
        end
    end

    // Display scan runs independently of key handling and en
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            prescale_reg <= '0;
            sel_reg      <= 3'd0;
        end else if (prescale_reg == PRE_LAST) begin
            prescale_reg <= '0;
            sel_reg      <= sel_reg + 3'd1;
        end else begin
            prescale_reg <= prescale_reg + PW'(1);
        end
    end

    assign kif.sel   = sel_reg;
    assign kif.out   = digit_reg[sel_reg];
    assign kif.blank = ({1'b0, sel_reg} >= count_reg);
    assign kif.count = count_reg;
    assign kif.full  = full_w;
    assign kif.err   = err_reg;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl (SCAN_DIV=4, DB_CYCLES=8); debounce steps
// are included when KEY_DEBOUNCE_EN is defined.
module tb_key_entry_ctrl;
    logic clk_50MHz = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   err_cycles = 0;

    key_entry_ctrl_if kif ();

    key_entry_ctrl #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .kif       (kif)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge, tallying err-high cycles
    task automatic tick();
        @(posedge clk_50MHz);
        #1;
        if (kif.err === 1'b1) err_cycles++;
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        err_cycles   = 0;
        kif.key      = k;
        kif.pressed  = 1'b1;
        repeat (hold) tick();
        kif.pressed  = 1'b0;
        repeat (3) tick();
        $display("press key=%h hold=%0d en=%0b -> count=%0d full=%0b err_cycles=%0d",
                 k, hold, kif.en, kif.count, kif.full, err_cycles);
    endtask

    // Sync to a 7->0 wrap, then check every digit slot over one full sweep
    task automatic sweep(input string tag, input logic [31:0] exp_out, input logic [7:0] exp_blank);
        logic [2:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = kif.sel;
            tick();
            if (prev == 3'd7 && kif.sel == 3'd0) found = 1'b1;
        end
        check({tag, "_sync"}, {31'd0, found}, 32'd1);
        for (int s = 0; s < 8; s++) begin
            check($sformatf("%s_sel%0d", tag, s), {29'd0, kif.sel}, s);
            check($sformatf("%s_out%0d", tag, s), {28'd0, kif.out}, {28'd0, exp_out[s*4 +: 4]});
            check($sformatf("%s_blank%0d", tag, s), {31'd0, kif.blank}, {31'd0, exp_blank[s]});
            repeat (4) tick();
        end
        check({tag, "_wrap"}, {29'd0, kif.sel}, 32'd0);
        $display("sweep %s done", tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        kif.pressed = 1'b0;
        kif.key     = 4'd0;
        kif.en      = 1'b0;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk_50MHz);
        #1;
        check("rst_sel",   {29'd0, kif.sel},   32'd0);
        check("rst_count", {28'd0, kif.count}, 32'd0);
        check("rst_full",  {31'd0, kif.full},  32'd0);
        check("rst_err",   {31'd0, kif.err},   32'd0);
        check("rst_out",   {28'd0, kif.out},   32'd0);
        check("rst_blank", {31'd0, kif.blank}, 32'd1);
        rst    = 1'b1;
        kif.en = 1'b1;

        // Keys 1,2,3
        press(4'h1, 10);
        press(4'h2, 10);
        press(4'h3, 10);
        check("abc_count", {28'd0, kif.count}, 32'd3);
        check("abc_full",  {31'd0, kif.full},  32'd0);
        sweep("abc", 32'h0000_0123, 8'b1111_1000);

        // Fill to eight digits, then overflow
        for (int d = 4; d <= 8; d++) press(4'(d), 10);
        check("fill_count", {28'd0, kif.count}, 32'd8);
        check("fill_full",  {31'd0, kif.full},  32'd1);
        press(4'h5, 10);
        check("ovf_count", {28'd0, kif.count}, 32'd8);
        check("ovf_err",   err_cycles,         32'd1);
        check("ovf_full",  {31'd0, kif.full},  32'd1);
        sweep("ovf", 32'h1234_5678, 8'b0000_0000);

        // Backspace from full
        press(4'hB, 10);
        check("bs_count", {28'd0, kif.count}, 32'd7);
        check("bs_full",  {31'd0, kif.full},  32'd0);
        check("bs_err",   err_cycles,         32'd0);
        sweep("bs", 32'h0123_4567, 8'b1000_0000);

        // Clear, then backspace on empty
        press(4'hC, 10);
        check("clr_count", {28'd0, kif.count}, 32'd0);
        check("clr_err",   err_cycles,         32'd0);
        press(4'hB, 10);
        check("bs0_count", {28'd0, kif.count}, 32'd0);
        check("bs0_err",   err_cycles,         32'd1);

        // Long hold gives one event
        press(4'h7, 50);
        check("hold_count", {28'd0, kif.count}, 32'd1);
        check("hold_err",   err_cycles,         32'd0);

        // Disabled entry
        kif.en = 1'b0;
        press(4'h4, 10);
        check("dis_count", {28'd0, kif.count}, 32'd1);
        check("dis_err",   err_cycles,         32'd0);
        kif.en = 1'b1;

        // No-op codes
        press(4'hA, 10);
        check("noA_err", err_cycles, 32'd0);
        press(4'hD, 10);
        press(4'hE, 10);
        press(4'hF, 10);
        check("noop_count", {28'd0, kif.count}, 32'd1);
        check("noop_err",   err_cycles,         32'd0);
        sweep("one", 32'h0000_0007, 8'b1111_1110);

        press(4'hC, 10);
        check("clr2_count", {28'd0, kif.count}, 32'd0);
        sweep("empty", 32'h0000_0000, 8'b1111_1111);

`ifdef KEY_DEBOUNCE_EN
        // Short bounce: 5 high cycles give no event
        err_cycles  = 0;
        kif.key     = 4'h9;
        kif.pressed = 1'b1;
        repeat (5) tick();
        kif.pressed = 1'b0;
        repeat (3) tick();
        $display("bounce key=9 high=5 -> count=%0d", kif.count);
        check("db_short_count", {28'd0, kif.count}, 32'd0);
        // Exactly DB_CYCLES high cycles give one event
        press(4'h9, 8);
        check("db_exact_count", {28'd0, kif.count}, 32'd1);
        check("db_exact_out0",  {28'd0, dut.digit_reg[0]}, 32'd9);
        press(4'hC, 10);
`endif

        // Key held across a reset pulse counts as a new press afterwards
        kif.key     = 4'h6;
        kif.pressed = 1'b1;
        repeat (20) tick();
        check("rsthold_pre",  {28'd0, kif.count}, 32'd1);
        rst = 1'b0;
        #1;
        check("rsthold_rst",  {28'd0, kif.count}, 32'd0);
        #20 rst = 1'b1;
        repeat (12) tick();
        check("rsthold_post", {28'd0, kif.count}, 32'd1);
        kif.pressed = 1'b0;
        repeat (3) tick();
        $display("reset-while-held key=6 -> count=%0d", kif.count);

        // Asynchronous reset mid-scan
        press(4'h2, 10);
        check("scan_count", {28'd0, kif.count}, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (kif.sel == 3'd3) found = 1'b1;
        end
        check("scan_reach3", {31'd0, found}, 32'd1);
        #3 rst = 1'b0;
        #1;
        check("async_sel",   {29'd0, kif.sel},   32'd0);
        check("async_count", {28'd0, kif.count}, 32'd0);
        check("async_blank", {31'd0, kif.blank}, 32'd1);
        check("async_full",  {31'd0, kif.full},  32'd0);
        $display("async reset mid-scan -> sel=%0d count=%0d", kif.sel, kif.count);
        #10 rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
